// File: rtl/im_port_arbiter.sv
// Single-port instruction memory arbiter: loader-only boot phase, then round-robin
// sharing between IF fetch (F) and loader/debug (L), with 1-cycle read return routing.
module im_port_arbiter #(
  parameter logic [31:0] BASE       = 32'h00003000,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [31:0]           l_addr,
  input  logic [31:0]           l_wdata,
  input  logic                  l_done,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [31:0]           l_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [DEPTH_LOG2-1:0] m_addr,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata,
  output logic                  booting,
  output logic                  err,
  output logic [DEPTH_LOG2:0]   boot_words
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] BW_MAX = CW'(1) << DEPTH_LOG2;

  typedef enum logic {ST_BOOT, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic        pref_l_q, pref_l_d;
  logic [31:0] sel_addr;
  logic [31:0] off;
  logic        in_range;
  logic        any_gnt;
  logic        is_wr;
  logic        rd_oor_q;
  logic [31:0] rd_data;
  logic [31:0] f_hold_q, l_hold_q;

  // State and contention pointer (pref_l_q=1: L wins the next contended cycle)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      pref_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pref_l_q <= pref_l_d;
    end
  end

  // Next state and grants
  always_comb begin
    state_d  = state_q;
    pref_l_d = pref_l_q;
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        l_gnt = l_req;
        if (l_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (f_req && l_req) begin
          l_gnt    = pref_l_q;
          f_gnt    = !pref_l_q;
          pref_l_d = !pref_l_q;
        end else begin
          f_gnt = f_req;
          l_gnt = l_req;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Address translation of the granted requester
  assign sel_addr = l_gnt ? l_addr : f_addr;
  assign off      = sel_addr - BASE;
  assign in_range = (off[31:DEPTH_LOG2+2] == '0) && (off[1:0] == 2'b00);
  assign any_gnt  = f_gnt | l_gnt;
  assign is_wr    = l_gnt & l_we;

  assign m_en    = any_gnt & in_range;
  assign m_we    = m_en & is_wr;
  assign m_addr  = off[DEPTH_LOG2+1:2];
  assign m_wdata = l_wdata;

  assign booting = (state_q == ST_BOOT);

  // Status, return tag and held read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      boot_words <= '0;
      f_rvalid   <= 1'b0;
      l_rvalid   <= 1'b0;
      rd_oor_q   <= 1'b0;
      f_hold_q   <= '0;
      l_hold_q   <= '0;
    end else begin
      if (any_gnt && !in_range) err <= 1'b1;
      if ((state_q == ST_BOOT) && is_wr && in_range && (boot_words != BW_MAX))
        boot_words <= boot_words + CW'(1);
      f_rvalid <= f_gnt;
      l_rvalid <= l_gnt & !l_we;
      rd_oor_q <= !in_range;
      if (f_rvalid) f_hold_q <= f_rdata;
      if (l_rvalid) l_hold_q <= l_rdata;
    end
  end

  // Memory data arrives the cycle after the grant, so the owner sees it directly
  assign rd_data = rd_oor_q ? 32'h0 : m_rdata;
  assign f_rdata = f_rvalid ? rd_data : f_hold_q;
  assign l_rdata = l_rvalid ? rd_data : l_hold_q;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: directed boot/run/error/reset sequences plus randomized
// traffic, checked against a word-array reference model and per-requester read queues.
module tb_im_port_arbiter;

  localparam logic [31:0] BASE = 32'h00003000;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_gnt, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_done, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [9:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic        booting, err;
  logic [10:0] boot_words;

  always #5 clk = ~clk;

  im_port_arbiter #(.BASE(BASE), .DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .booting(booting), .err(err), .boot_words(boot_words)
  );

  // Instruction memory with 1-cycle read latency
  logic [31:0] mem [1024];
  logic [31:0] mem_rdata = 32'h0;
  assign m_rdata = mem_rdata;
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      mem_rdata   <= mem[m_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [1024];
  bit          m_boot, m_err;
  int          m_bw;
  int          last_win;   // 1 = F, 2 = L won the last contended cycle
  logic [31:0] f_q[$], l_q[$];
  logic [31:0] last_f, last_l, mon_exp;
  bit          e_fg, e_lg;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, check comb and registered outputs, advance model
  task automatic cyc(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                     input logic [31:0] la, input logic [31:0] lwd, input bit ld);
    logic [31:0] a, off, d;
    bit ok, wr;
    @(negedge clk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd; l_done = ld;
    #2;
    chk("booting", booting, m_boot);
    chk("err", err, m_err);
    chk("boot_words", boot_words, m_bw);
    e_fg = 0; e_lg = 0;
    if (m_boot) e_lg = lr;
    else if (fr && lr) begin
      if (last_win == 1) e_lg = 1; else e_fg = 1;
      last_win = e_fg ? 1 : 2;
    end else begin
      e_fg = fr; e_lg = lr;
    end
    chk("f_gnt", f_gnt, e_fg);
    chk("l_gnt", l_gnt, e_lg);
    if (e_fg || e_lg) begin
      a   = e_lg ? la : fa;
      off = a - BASE;
      ok  = (off < 4096) && (off % 4 == 0);
      wr  = e_lg && lw;
      chk("m_en", m_en, ok);
      if (ok) begin
        chk("m_addr", m_addr, off / 4);
        chk("m_we", m_we, wr);
        if (wr) chk("m_wdata", m_wdata, lwd);
      end else m_err = 1;
      if (wr && ok) begin
        ref_mem[off / 4] = lwd;
        if (m_boot && m_bw < 1024) m_bw++;
      end
      if (!wr) begin
        d = ok ? ref_mem[off / 4] : 32'h0;
        if (e_fg) f_q.push_back(d); else l_q.push_back(d);
      end
    end else chk("m_en_idle", m_en, 0);
    if (m_boot && ld) m_boot = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset now (mid-cycle), check immediate outputs, release two cycles later
  task automatic apply_reset();
    reset = 1'b0;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_done = 0;
    m_boot = 1; m_err = 0; m_bw = 0; last_win = 2;
    f_q.delete(); l_q.delete();
    last_f = 0; last_l = 0;
    #1;
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_booting", booting, 1);
    chk("rst_err", err, 0);
    chk("rst_boot_words", boot_words, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_gnt", {f_gnt, l_gnt}, 0);
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
  endtask

  // Read-return monitor: every queued read must return on the following edge
  always @(posedge clk) begin
    #1;
    if (f_rvalid) begin
      if (f_q.size() == 0) chk("f_rvalid_unexpected", 1, 0);
      else begin
        mon_exp = f_q.pop_front();
        chk("f_rdata", f_rdata, mon_exp);
        last_f = mon_exp;
      end
    end else chk("f_rdata_hold", f_rdata, last_f);
    if (l_rvalid) begin
      if (l_q.size() == 0) chk("l_rvalid_unexpected", 1, 0);
      else begin
        mon_exp = l_q.pop_front();
        chk("l_rdata", l_rdata, mon_exp);
        last_l = mon_exp;
      end
    end else chk("l_rdata_hold", l_rdata, last_l);
    chk("rvalid_exclusive", {31'h0, f_rvalid & l_rvalid}, 0);
    if (f_q.size() != 0) begin chk("f_rvalid_missing", f_q.size(), 0); f_q.delete(); end
    if (l_q.size() != 0) begin chk("l_rvalid_missing", l_q.size(), 0); l_q.delete(); end
  end

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom % 16);
    case (r)
      0:       return BASE - 32'd4;
      1:       return BASE + 32'd4096;
      2:       return BASE + 32'(4 * $urandom_range(0, 1023)) + 32'd2;
      3:       return BASE + 32'(4 * $urandom_range(0, 1023));
      default: return BASE + 32'(4 * $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    bit pf, pl, lw;
    logic [31:0] fa, la, lwd;
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    reset = 1'b1;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_done = 0;
    last_f = 0; last_l = 0;
    #1;
    apply_reset();

    // Fetch is never granted during boot
    repeat (5) cyc(1, BASE, 0, 0, 0, 0, 0);
    // Two boot writes; the second coincides with l_done and still counts
    cyc(0, 0, 1, 1, BASE, 32'h24080001, 0);
    cyc(0, 0, 1, 1, BASE + 4, 32'h24090002, 1);
    cyc(1, BASE + 4, 0, 0, 0, 0, 0);
    idle();
    // Contended reads alternate F, L, F, L
    repeat (4) cyc(1, BASE + 4, 1, 0, BASE, 0, 0);
    idle();
    // Out-of-range read, out-of-range write, misaligned read
    cyc(1, 32'h00002FFC, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h00004000, 32'hDEADBEEF, 0);
    cyc(1, BASE + 2, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Fresh boot filling the whole memory past saturation, with L reads mixed in
    apply_reset();
    cyc(0, 0, 1, 0, BASE + 4, 0, 0);
    for (int i = 0; i < 1030; i++)
      cyc(1, BASE + 8, 1, 1, BASE + 32'(4 * (i % 1024)), $urandom, 0);
    cyc(1, BASE + 8, 1, 0, BASE + 12, 0, 1);
    idle();

    // Randomized run traffic; requests are held until granted
    pf = 0; pl = 0; lw = 0; fa = 0; la = 0; lwd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pf && ($urandom % 4 != 0)) begin pf = 1; fa = rand_addr(); end
      if (!pl && ($urandom % 3 == 0)) begin
        pl = 1; lw = bit'($urandom % 2); la = rand_addr(); lwd = $urandom;
      end
      cyc(pf, fa, pl, lw, la, lwd, bit'($urandom % 16 == 0));
      if (e_fg) pf = 0;
      if (e_lg) pl = 0;
    end
    idle();
    cyc(1, 32'h00002FFC, 0, 0, 0, 0, 0);
    idle();
    idle();

    // Reset while a fetch read is outstanding: its return must never appear
    cyc(1, BASE + 8, 0, 0, 0, 0, 0);
    #1;
    apply_reset();
    idle();
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Owns the single port of the 1024-word instruction memory and shares it between two requesters.
- Requester F is the IF-stage fetch; requester L is the code loader/debug port.
- Sequences a boot phase (loader-only) after reset, then round-robin arbitrates in run phase.
- Translates byte addresses to word indices, flags out-of-range accesses, and routes 1-cycle-latency read data back to the correct requester.

Parameters:
- BASE, 32'h00003000, byte address mapped to word index 0.
- DEPTH_LOG2, 10, log2 of memory words (1024).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch read request.
- f_addr  in  32  fetch byte address (PC).
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  32  fetch read data (instr).
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_done  in  1  loader signals end of boot image (single-cycle pulse).
- l_gnt  out  1  loader request accepted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  32  loader read data.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  DEPTH_LOG2  memory word index.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; valid the cycle after m_en with m_we=0.
- booting  out  1  1 while in BOOT state.
- err  out  1  sticky out-of-range / misaligned access flag.
- boot_words  out  DEPTH_LOG2+1  count of words written during BOOT (saturates at 2^DEPTH_LOG2).

Behaviour:
- Reset (reset=0, async):
  - state=BOOT; booting=1; err=0; boot_words=0.
  - RR pointer = F-preferred.
  - All gnt/rvalid/m_en/m_we = 0; rdata outputs = 0.
- Address translation:
  - off = addr - BASE.
  - In range iff off[31:DEPTH_LOG2+2]==0 and off[1:0]==0.
  - m_addr = off[DEPTH_LOG2+1:2].
- Grant logic is combinational from req and state; all outputs other than gnt/m_* are registered.
- BOOT state:
  - Only L is granted; f_gnt=0 regardless of f_req.
  - Each granted in-range L write increments boot_words.
  - L reads are allowed.
  - l_done=1 moves state to RUN at the next edge.
  - A write granted in the same cycle as l_done still completes and still counts.
- RUN state:
  - If exactly one requester is active, it is granted.
  - If both are active, the requester not granted most recently wins (round-robin).
  - The pointer updates only on a contended grant.
  - l_done is ignored in RUN.
- Granted access:
  - m_en=1, m_we=l_we (0 for F), m_addr and m_wdata driven the same cycle.
- Out-of-range or misaligned grant:
  - m_en=0; err set (sticky until reset).
  - For a read, the owner still receives rvalid next cycle with rdata=0.
  - A write is dropped and not counted.
- Read return:
  - Registered owner tag records who was granted a read.
  - Next cycle: owner's rvalid=1 and rdata=m_rdata (or 0 if out-of-range).
  - The other requester's rvalid=0 and rdata is held.
  - Writes never produce rvalid.
- Back-to-back grants every cycle are supported (throughput 1/cycle); the return pipeline is 1 deep.
- A requester must hold req/addr until it sees gnt.
- Reset asserted mid-transaction:
  - Pending rvalid is discarded.
  - Returns to BOOT; boot_words and err are cleared.
  - Memory contents are untouched.

Test Plan:
- Reset release, f_req=1 f_addr=32'h3000 for 5 cycles, no L activity -> f_gnt=0 throughout, booting=1, m_en=0.
- BOOT: L writes 32'h24080001 to 0x3000 and 32'h24090002 to 0x3004, then pulses l_done -> m_addr=0 then 1 with m_we=1, boot_words=2, booting=0 next cycle.
- RUN: f_req with f_addr=0x3004, memory returns 32'h24090002 -> f_gnt same cycle, f_rvalid=1 with f_rdata=32'h24090002 one cycle later, l_rvalid=0.
- RUN contention: f_req and l_req (read 0x3000) held 4 cycles -> grants alternate F,L,F,L; each rvalid lands on the correct side with matching data.
- Out-of-range: f_addr=32'h2FFC, then l_addr=32'h4000 write, then misaligned 0x3002 -> m_en=0 for each; f_rvalid=1 with f_rdata=0; err=1 and stays 1.
- Async reset asserted mid-cycle while an F read is outstanding -> no f_rvalid; outputs zero immediately; booting=1, err=0, boot_words=0.
